interrupt_ctrl8227: RTL and testbench
=====================================

# interrupt_ctrl8227

Interrupt front end sitting directly upstream of `top8227`, driving its `nonMaskableInterrupt` and `interruptRequest` inputs. It synchronizes the raw, active-low external NMI pin and `NUM_IRQ` IRQ pins to `clk`. It latches NMI falling edges and latches or passes IRQ sources according to a per-source mode, then applies per-source masks. It retires a pending NMI by snooping the CPU address bus for the NMI vector fetch.

## Interface
- `NUM_IRQ`, 4: number of IRQ source pins (1–8).
- `SYNC_STAGES`, 2: synchronizer depth per pin (≥2).
- `NMI_VECTOR_ADDR`, 16'hFFFA: address whose appearance on the bus acknowledges NMI.
- `clk` in 1: system clock, same clock as `top8227`.
- `nrst` in 1: reset, synchronous, active-low.
- `nmiPin` in 1: external NMI, asynchronous, active-low, falling-edge significant.
- `irqPins` in NUM_IRQ: external IRQ sources, asynchronous, active-low.
- `irqEdgeMode` in NUM_IRQ: per source, 1 = latch falling edge, 0 = level.
- `irqMask` in NUM_IRQ: per source, 1 = masked.
- `irqClear` in NUM_IRQ: per-source clear of edge-latched pending; single-cycle pulse.
- `AddressBusHigh` in 8: CPU address high byte.
- `AddressBusLow` in 8: CPU address low byte.
- `nonMaskableInterrupt` out 1: to CPU, active-high.
- `interruptRequest` out 1: to CPU, active-high.
- `irqPending` out NUM_IRQ: raw pending status, before masking.

## Operation
- Each pin passes through `SYNC_STAGES` flops, then an edge-detect flop.
  - All of these flops reset to 1 (inactive), so there is no spurious edge on reset release.
  - A falling edge is detected when the last sync stage is 0 and the edge flop is 1.
- NMI pending register:
  - Set on a detected falling edge.
  - Cleared at a rising edge where `{AddressBusHigh,AddressBusLow}==NMI_VECTOR_ADDR`.
  - Edge and ack in the same cycle: pending remains 1 (the new edge wins).
  - Holding the pin low does not re-trigger; a new falling edge is required.
- `nonMaskableInterrupt` = the NMI pending flop.
- IRQ source i, level mode: `pending[i]` = inverse of the last sync stage of pin i, registered.
- IRQ source i, edge mode:
  - `pending[i]` is set on a falling edge.
  - It is cleared by `irqClear[i]`.
  - Edge and clear in the same cycle: stays set.
  - `irqClear` has no effect in level mode.
- A change in `irqEdgeMode[i]` takes effect at the next edge. Switching edge→level makes pending follow the pin from that cycle.
- `interruptRequest` is a flop loaded with OR(next_pending & ~irqMask).
- `irqPending` = the pending flops.
- Reset (synchronous, `nrst`=0 at a rising edge), including mid-operation:
  - all outputs 0;
  - all pending registers cleared;
  - sync and edge flops set to 1.

## Timing
- Pin low set up before rising edge k: NMI pending, and `nonMaskableInterrupt`, are high after edge k+SYNC_STAGES. With the default depth this is edge k+2, i.e. 3 edges total.
- IRQ pin: `irqPending[i]` and `interruptRequest` rise after the same edge (k+SYNC_STAGES).
- Level IRQ release: the output falls the same number of edges after the pin rises.
- NMI ack: address presented before edge a → `nonMaskableInterrupt` is 0 after edge a.
- `irqMask` / `irqClear`: a change sampled at edge m is reflected in `interruptRequest` after edge m.
- No combinational path from any input to any output.

## Configuration
- `INTCTRL_PRIORITY_ID_EN` defined adds two outputs:
  - `irqId` (3 bits): index of the lowest-numbered unmasked pending source, registered alongside `interruptRequest`.
  - `irqIdValid` (1 bit): equals `interruptRequest`.
  - Both outputs reset to 0.
- Undefined: neither port exists, and the priority encoder is not built.

## Structure
- Package `intctrl8227_pkg`:
  - default `NMI_VECTOR_ADDR`;
  - max IRQ count constant (8);
  - `irq_mode_e` enum (`IRQ_LEVEL`=0, `IRQ_EDGE`=1).
- Sub-module `pin_sync_edge`: synchronizer chain plus falling-edge detect.
  - Parameter `SYNC_STAGES`.
  - Outputs `syncLevel` and `fallEdge`.
  - Instantiated NUM_IRQ+1 times.

## Test plan
- **Reset:** `nrst`=0 for 2 cycles with all pins low → all outputs 0, `irqPending`=4'b0000. Release with pins high → no pending for 10 cycles.
- **NMI:** drive `nmiPin` low before edge k → `nonMaskableInterrupt`=1 after edge k+2 and stays 1 while the pin is held low. Present address 16'hFFFA for one cycle → 0 next edge. Address 16'hFFFB → no clear.
- **NMI collision:** new falling edge reaching the detector in the same cycle as the 16'hFFFA ack → `nonMaskableInterrupt` stays 1.
- **Level IRQ:** `irqEdgeMode`=4'b0000, pin 2 low → `irqPending`=4'b0100 and `interruptRequest`=1 after 2 edges.
  - Set `irqMask`=4'b0100 → `interruptRequest`=0 next edge while `irqPending` stays 4'b0100.
  - Release the pin → `irqPending`=0 after 2 edges.
- **Edge IRQ:** `irqEdgeMode`=4'b0001, 1-cycle low pulse on pin 0 → `irqPending[0]` latched 1 indefinitely. Pulse `irqClear`=4'b0001 → 0. Edge coinciding with clear → remains 1.
- **Priority (with `INTCTRL_PRIORITY_ID_EN`):** pins 1 and 3 pending, mask 4'b0000 → `irqId`=1. Mask 4'b0010 → `irqId`=3.

Source files
------------

// File: rtl/interrupt_ctrl8227_pkg.sv
// ---------------------------------------------------------------
// intctrl8227_pkg : shared constants and types for interrupt_ctrl8227
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

package intctrl8227_pkg;

  localparam logic [15:0] NMI_VECTOR_ADDR_DEFAULT = 16'hFFFA;
  localparam int          MAX_IRQ                 = 8;

  typedef enum logic {
    IRQ_LEVEL = 1'b0,
    IRQ_EDGE  = 1'b1
  } irq_mode_e;

  // Index of the lowest set bit; 0 when the vector is empty.
  function automatic logic [2:0] lowest_set(input logic [MAX_IRQ-1:0] v);
    lowest_set = 3'd0;
    for (int i = MAX_IRQ - 1; i >= 0; i--) begin
      if (v[i]) lowest_set = 3'(i);
    end
  endfunction

endpackage

`default_nettype wire

// File: rtl/interrupt_ctrl8227_pin_sync_edge.sv
// ---------------------------------------------------------------
// pin_sync_edge : async active-low pin synchronizer + falling-edge detect
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module pin_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic nrst,
  input  logic pinN,
  output logic syncLevel,
  output logic fallEdge
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   edge_q, edge_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], pinN};
    edge_d = sync_q[SYNC_STAGES-1];
  end

  // Everything resets to the inactive level so reset release never looks like an edge.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      sync_q <= '1;
      edge_q <= 1'b1;
    end else begin
      sync_q <= sync_d;
      edge_q <= edge_d;
    end
  end

  assign syncLevel = sync_q[SYNC_STAGES-1];
  assign fallEdge  = ~sync_q[SYNC_STAGES-1] & edge_q;

endmodule

`default_nettype wire

// File: rtl/interrupt_ctrl8227.sv
// ---------------------------------------------------------------
// interrupt_ctrl8227 : NMI/IRQ front end for top8227 (optional INTCTRL_PRIORITY_ID_EN)
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module interrupt_ctrl8227
  import intctrl8227_pkg::*;
#(
  parameter int          NUM_IRQ         = 4,
  parameter int          SYNC_STAGES     = 2,
  parameter logic [15:0] NMI_VECTOR_ADDR = NMI_VECTOR_ADDR_DEFAULT
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic               nmiPin,
  input  logic [NUM_IRQ-1:0] irqPins,
  input  logic [NUM_IRQ-1:0] irqEdgeMode,
  input  logic [NUM_IRQ-1:0] irqMask,
  input  logic [NUM_IRQ-1:0] irqClear,
  input  logic [7:0]         AddressBusHigh,
  input  logic [7:0]         AddressBusLow,
  output logic               nonMaskableInterrupt,
  output logic               interruptRequest,
  output logic [NUM_IRQ-1:0] irqPending
`ifdef INTCTRL_PRIORITY_ID_EN
  ,
  output logic [2:0]         irqId,
  output logic               irqIdValid
`endif
);

  // Bit 0 is NMI, bits 1..NUM_IRQ are the IRQ pins.
  logic [NUM_IRQ:0] pins_n;
  logic [NUM_IRQ:0] sync_level;
  logic [NUM_IRQ:0] fall;

  assign pins_n = {irqPins, nmiPin};

  generate
    for (genvar g = 0; g <= NUM_IRQ; g++) begin : g_sync
      pin_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
      ) u_sync (
        .clk      (clk),
        .nrst     (nrst),
        .pinN     (pins_n[g]),
        .syncLevel(sync_level[g]),
        .fallEdge (fall[g])
      );
    end
  endgenerate

  logic               nmi_q, nmi_d;
  logic [NUM_IRQ-1:0] pend_q, pend_d;
  logic               req_q, req_d;
  logic               nmi_ack;

  assign nmi_ack = ({AddressBusHigh, AddressBusLow} == NMI_VECTOR_ADDR);

  always_comb begin
    nmi_d = nmi_q;
    // A new edge takes precedence over a simultaneous vector-fetch acknowledge.
    if (fall[0] && !sync_level[0]) begin
      nmi_d = 1'b1;
    end else if (nmi_ack) begin
      nmi_d = 1'b0;
    end

    pend_d = pend_q;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (irq_mode_e'(irqEdgeMode[i]) == IRQ_EDGE) begin
        pend_d[i] = fall[i+1] | (pend_q[i] & ~irqClear[i]);
      end else begin
        pend_d[i] = ~sync_level[i+1];
      end
    end

    req_d = |(pend_d & ~irqMask);
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      nmi_q  <= 1'b0;
      pend_q <= '0;
      req_q  <= 1'b0;
    end else begin
      nmi_q  <= nmi_d;
      pend_q <= pend_d;
      req_q  <= req_d;
    end
  end

  assign nonMaskableInterrupt = nmi_q;
  assign interruptRequest     = req_q;
  assign irqPending           = pend_q;

`ifdef INTCTRL_PRIORITY_ID_EN
  logic [MAX_IRQ-1:0] masked_ext;
  logic [2:0]         id_q, id_d;

  always_comb begin
    masked_ext              = '0;
    masked_ext[NUM_IRQ-1:0] = pend_d & ~irqMask;
    id_d                    = lowest_set(masked_ext);
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      id_q <= 3'd0;
    end else begin
      id_q <= id_d;
    end
  end

  assign irqId      = id_q;
  assign irqIdValid = req_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_interrupt_ctrl8227.sv
// ---------------------------------------------------------------
// tb_interrupt_ctrl8227 : directed vector bench for interrupt_ctrl8227
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module tb_interrupt_ctrl8227;

  logic        clk;
  logic        nrst;
  logic        nmiPin;
  logic [3:0]  irqPins, irqEdgeMode, irqMask, irqClear;
  logic [7:0]  AddressBusHigh, AddressBusLow;
  logic        nonMaskableInterrupt, interruptRequest;
  logic [3:0]  irqPending;
`ifdef INTCTRL_PRIORITY_ID_EN
  logic [2:0]  irqId;
  logic        irqIdValid;
`endif

  interrupt_ctrl8227 dut (
    .clk                 (clk),
    .nrst                (nrst),
    .nmiPin              (nmiPin),
    .irqPins             (irqPins),
    .irqEdgeMode         (irqEdgeMode),
    .irqMask             (irqMask),
    .irqClear            (irqClear),
    .AddressBusHigh      (AddressBusHigh),
    .AddressBusLow       (AddressBusLow),
    .nonMaskableInterrupt(nonMaskableInterrupt),
    .interruptRequest    (interruptRequest),
    .irqPending          (irqPending)
`ifdef INTCTRL_PRIORITY_ID_EN
    ,
    .irqId               (irqId),
    .irqIdValid          (irqIdValid)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        nmi;
    logic [3:0]  irq;
    logic [3:0]  mode;
    logic [3:0]  mask;
    logic [3:0]  clr;
    logic [15:0] addr;
    logic        e_nmi;
    logic        e_req;
    logic [3:0]  e_pend;
  } vec_t;

  vec_t tbl[23];

  function automatic vec_t mk(input logic n, input logic [3:0] irq, input logic [3:0] mode,
                              input logic [3:0] mask, input logic [3:0] clr,
                              input logic [15:0] addr, input logic en, input logic er,
                              input logic [3:0] ep);
    vec_t v;
    v.nmi = n; v.irq = irq; v.mode = mode; v.mask = mask; v.clr = clr; v.addr = addr;
    v.e_nmi = en; v.e_req = er; v.e_pend = ep;
    return v;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_addr(input logic [15:0] a);
    AddressBusHigh = a[15:8];
    AddressBusLow  = a[7:0];
  endtask

  initial begin
    // NMI assert/hold/ack, level IRQ with masking and release, edge IRQ latch and clear.
    tbl[0]  = mk(1'b0, 4'hF, 4'h0, 4'h0, 4'h0, 16'h0000, 1'b0, 1'b0, 4'h0);
    tbl[1]  = mk(1'b0, 4'hF, 4'h0, 4'h0, 4'h0, 16'h0000, 1'b0, 1'b0, 4'h0);
    tbl[2]  = mk(1'b0, 4'hF, 4'h0, 4'h0, 4'h0, 16'h0000, 1'b1, 1'b0, 4'h0);
    tbl[3]  = mk(1'b0, 4'hF, 4'h0, 4'h0, 4'h0, 16'h0000, 1'b1, 1'b0, 4'h0);
    tbl[4]  = mk(1'b0, 4'hF, 4'h0, 4'h0, 4'h0, 16'hFFFB, 1'b1, 1'b0, 4'h0);
    tbl[5]  = mk(1'b0, 4'hF, 4'h0, 4'h0, 4'h0, 16'hFFFA, 1'b0, 1'b0, 4'h0);
    tbl[6]  = mk(1'b0, 4'hF, 4'h0, 4'h0, 4'h0, 16'h0000, 1'b0, 1'b0, 4'h0);
    tbl[7]  = mk(1'b1, 4'hF, 4'h0, 4'h0, 4'h0, 16'h0000, 1'b0, 1'b0, 4'h0);
    tbl[8]  = mk(1'b1, 4'hF, 4'h0, 4'h0, 4'h0, 16'h0000, 1'b0, 1'b0, 4'h0);
    tbl[9]  = mk(1'b1, 4'hB, 4'h0, 4'h0, 4'h0, 16'h0000, 1'b0, 1'b0, 4'h0);
    tbl[10] = mk(1'b1, 4'hB, 4'h0, 4'h0, 4'h0, 16'h0000, 1'b0, 1'b0, 4'h0);
    tbl[11] = mk(1'b1, 4'hB, 4'h0, 4'h0, 4'h0, 16'h0000, 1'b0, 1'b1, 4'h4);
    tbl[12] = mk(1'b1, 4'hB, 4'h0, 4'h4, 4'h0, 16'h0000, 1'b0, 1'b0, 4'h4);
    tbl[13] = mk(1'b1, 4'hF, 4'h0, 4'h4, 4'h0, 16'h0000, 1'b0, 1'b0, 4'h4);
    tbl[14] = mk(1'b1, 4'hF, 4'h0, 4'h4, 4'h0, 16'h0000, 1'b0, 1'b0, 4'h4);
    tbl[15] = mk(1'b1, 4'hF, 4'h0, 4'h4, 4'h0, 16'h0000, 1'b0, 1'b0, 4'h0);
    tbl[16] = mk(1'b1, 4'hE, 4'h1, 4'h0, 4'h0, 16'h0000, 1'b0, 1'b0, 4'h0);
    tbl[17] = mk(1'b1, 4'hF, 4'h1, 4'h0, 4'h0, 16'h0000, 1'b0, 1'b0, 4'h0);
    tbl[18] = mk(1'b1, 4'hF, 4'h1, 4'h0, 4'h0, 16'h0000, 1'b0, 1'b1, 4'h1);
    tbl[19] = mk(1'b1, 4'hF, 4'h1, 4'h0, 4'h0, 16'h0000, 1'b0, 1'b1, 4'h1);
    tbl[20] = mk(1'b1, 4'hF, 4'h1, 4'h0, 4'h0, 16'h0000, 1'b0, 1'b1, 4'h1);
    tbl[21] = mk(1'b1, 4'hF, 4'h1, 4'h0, 4'h1, 16'h0000, 1'b0, 1'b0, 4'h0);
    tbl[22] = mk(1'b1, 4'hF, 4'h1, 4'h0, 4'h0, 16'h0000, 1'b0, 1'b0, 4'h0);

    // Reset with all pins low.
    nrst = 1'b0; nmiPin = 1'b0; irqPins = 4'h0;
    irqEdgeMode = 4'h0; irqMask = 4'h0; irqClear = 4'h0; set_addr(16'h0000);
    step(); step();
    check("rst_nmi",  16'(nonMaskableInterrupt), 16'h0);
    check("rst_req",  16'(interruptRequest),     16'h0);
    check("rst_pend", 16'(irqPending),           16'h0);
`ifdef INTCTRL_PRIORITY_ID_EN
    check("rst_id",    16'(irqId),      16'h0);
    check("rst_idval", 16'(irqIdValid), 16'h0);
`endif

    // Release with pins high: nothing may become pending.
    nrst = 1'b1; nmiPin = 1'b1; irqPins = 4'hF;
    for (int c = 0; c < 10; c++) begin
      step();
      check($sformatf("idle%0d_pend", c), 16'(irqPending), 16'h0);
      check($sformatf("idle%0d_nmi", c), 16'(nonMaskableInterrupt), 16'h0);
    end

    for (int i = 0; i < 23; i++) begin
      nmiPin = tbl[i].nmi; irqPins = tbl[i].irq; irqEdgeMode = tbl[i].mode;
      irqMask = tbl[i].mask; irqClear = tbl[i].clr; set_addr(tbl[i].addr);
      step();
      check($sformatf("row%0d_nmi", i),  16'(nonMaskableInterrupt), 16'(tbl[i].e_nmi));
      check($sformatf("row%0d_req", i),  16'(interruptRequest),     16'(tbl[i].e_req));
      check($sformatf("row%0d_pend", i), 16'(irqPending),           16'(tbl[i].e_pend));
    end

    // NMI collision: new edge detected in the same cycle as the vector-fetch ack.
    nmiPin = 1'b0; step(); step(); step();
    check("col_nmi_set", 16'(nonMaskableInterrupt), 16'h1);
    nmiPin = 1'b1; step();
    nmiPin = 1'b0; step(); step();
    set_addr(16'hFFFA); step();
    check("col_nmi_keep", 16'(nonMaskableInterrupt), 16'h1);
    step();
    check("col_nmi_ack", 16'(nonMaskableInterrupt), 16'h0);
    set_addr(16'h0000); nmiPin = 1'b1; step(); step();

    // Edge IRQ collision: second edge coincides with clear.
    irqEdgeMode = 4'h1;
    irqPins = 4'hE; step();
    irqPins = 4'hF; step(); step();
    check("ecol_first", 16'(irqPending), 16'h1);
    irqPins = 4'hE; step();
    irqPins = 4'hF; step();
    irqClear = 4'h1; step();
    check("ecol_keep", 16'(irqPending), 16'h1);
    step();
    check("ecol_clear", 16'(irqPending), 16'h0);
    irqClear = 4'h0;

    // Level mode ignores clear; NMI pending then both wiped by mid-operation reset.
    irqEdgeMode = 4'h0; irqPins = 4'h7; nmiPin = 1'b0;
    step(); step(); step();
    check("lvl3_pend", 16'(irqPending), 16'h8);
    check("lvl3_nmi",  16'(nonMaskableInterrupt), 16'h1);
    irqClear = 4'h8; step();
    check("lvl3_clr_ignored", 16'(irqPending), 16'h8);
    check("lvl3_req", 16'(interruptRequest), 16'h1);
    irqClear = 4'h0;
    nrst = 1'b0; step();
    check("midrst_nmi",  16'(nonMaskableInterrupt), 16'h0);
    check("midrst_req",  16'(interruptRequest),     16'h0);
    check("midrst_pend", 16'(irqPending),           16'h0);
    nmiPin = 1'b1; irqPins = 4'hF; nrst = 1'b1; step(); step();
    check("post_rst_pend", 16'(irqPending), 16'h0);

`ifdef INTCTRL_PRIORITY_ID_EN
    irqPins = 4'h5; irqMask = 4'h0;
    step(); step(); step();
    check("prio_pend",  16'(irqPending), 16'hA);
    check("prio_id1",   16'(irqId),      16'h1);
    check("prio_val1",  16'(irqIdValid), 16'h1);
    irqMask = 4'h2; step();
    check("prio_id3",   16'(irqId),      16'h3);
    check("prio_val3",  16'(irqIdValid), 16'h1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
